// File: rtl/sdram_burst_read.sv
// SDRAM burst-read engine: ACTIVE, then READ with auto-precharge, BURST_LEN beat capture, tRP wait.
// Optional build macro SDRAM_BURST_READ_DQ_REG_EN inserts an input register stage on DRAM_DQ.
module sdram_burst_read #(
   parameter int ROW_W     = 13,
   parameter int COL_W     = 10,
   parameter int BANK_W    = 2,
   parameter int DATA_W    = 16,
   parameter int T_RCD     = 2,
   parameter int CAS_LAT   = 3,
   parameter int BURST_LEN = 4,
   parameter int T_RP      = 2
) (
   input  logic                  iclk,
   input  logic                  irst_n,
   input  logic                  ireq,
   input  logic                  ienb,
   input  logic [ROW_W-1:0]      irow,
   input  logic [COL_W-1:0]      icolumn,
   input  logic [BANK_W-1:0]     ibank,
   output logic                  obusy,
   output logic [DATA_W-1:0]     odata,
   output logic                  ovalid,
   output logic [((BURST_LEN > 1) ? $clog2(BURST_LEN) : 1)-1:0] obeat,
   output logic                  ofin,
   output wire logic             DRAM_CLK,
   output wire logic             DRAM_CKE,
   output wire logic [ROW_W-1:0] DRAM_ADDR,
   output wire logic [BANK_W-1:0] DRAM_BA,
   output wire logic             DRAM_CS_N,
   output wire logic             DRAM_RAS_N,
   output wire logic             DRAM_CAS_N,
   output wire logic             DRAM_WE_N,
   output wire logic             DRAM_UDQM,
   output wire logic             DRAM_LDQM,
   input  logic [DATA_W-1:0]     DRAM_DQ
);

`ifdef SDRAM_BURST_READ_DQ_REG_EN
   localparam int DQ_REG = 1;
`else
   localparam int DQ_REG = 0;
`endif
   localparam int OBEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int BEAT_W  = $clog2(BURST_LEN) + 1;
   // The DQ input stage delays the last beat by one cycle, so the precharge wait grows to match.
   localparam int RP_LEN  = T_RP + DQ_REG;
   localparam int WAIT_W  = $clog2(T_RCD + CAS_LAT + RP_LEN + 2) + 1;

   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_ACT  = 4'b0011;
   localparam logic [3:0] CMD_READ = 4'b0101;

   if (!(CAS_LAT == 2 || CAS_LAT == 3)) begin : g_bad_cas_lat
      $error("sdram_burst_read: CAS_LAT must be 2 or 3");
   end
   if (!(BURST_LEN == 1 || BURST_LEN == 2 || BURST_LEN == 4 || BURST_LEN == 8)) begin : g_bad_burst_len
      $error("sdram_burst_read: BURST_LEN must be 1, 2, 4 or 8");
   end
   if (T_RCD < 1) begin : g_bad_t_rcd
      $error("sdram_burst_read: T_RCD must be at least 1");
   end
   if (T_RP < 1) begin : g_bad_t_rp
      $error("sdram_burst_read: T_RP must be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACT,
      S_RCD,
      S_RD,
      S_CL,
      S_DATA,
      S_RP
   } state_t;

   state_t              state;
   logic [3:0]          cmd_q;
   logic [ROW_W-1:0]    addr_q;
   logic [BANK_W-1:0]   ba_q;
   logic                dqm_q;
   logic [COL_W-1:0]    col_q;
   logic [BANK_W-1:0]   bank_q;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [BEAT_W-1:0]   beat_cnt;
   logic [ROW_W-1:0]    rd_addr;
   logic                rd_now;
   logic                cap_valid;
   logic [DATA_W-1:0]   cap_data;
   logic [OBEAT_W-1:0]  cap_beat;

   assign obusy = (state != S_IDLE);

   // Column on the low bits, A10 set to request auto-precharge.
   always_comb begin
      rd_addr = '0;
      rd_addr[COL_W-1:0] = col_q;
      rd_addr[10] = 1'b1;
   end

   assign rd_now = ((state == S_ACT) && (T_RCD == 1)) ||
                   ((state == S_RCD) && (wait_cnt == '0));

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state    <= S_IDLE;
         cmd_q    <= CMD_NOP;
         addr_q   <= '0;
         ba_q     <= '0;
         dqm_q    <= 1'b1;
         col_q    <= '0;
         bank_q   <= '0;
         wait_cnt <= '0;
         beat_cnt <= '0;
         ofin     <= 1'b0;
      end else begin
         cmd_q <= CMD_NOP;
         ofin  <= 1'b0;
         if (rd_now) begin
            cmd_q  <= CMD_READ;
            addr_q <= rd_addr;
            ba_q   <= bank_q;
            dqm_q  <= 1'b0;
            state  <= S_RD;
         end else begin
            case (state)
               S_IDLE: begin
                  if (ireq) begin
                     col_q  <= icolumn;
                     bank_q <= ibank;
                     cmd_q  <= CMD_ACT;
                     addr_q <= irow;
                     ba_q   <= ibank;
                     state  <= S_ACT;
                  end
               end
               S_ACT: begin
                  wait_cnt <= WAIT_W'(T_RCD - 2);
                  state    <= S_RCD;
               end
               S_RCD: begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
               // The READ cycle itself counts toward CAS latency, so CL holds CAS_LAT-1 cycles.
               S_RD: begin
                  wait_cnt <= WAIT_W'(CAS_LAT - 2);
                  state    <= S_CL;
               end
               S_CL: begin
                  if (wait_cnt == '0) begin
                     beat_cnt <= '0;
                     state    <= S_DATA;
                  end else begin
                     wait_cnt <= wait_cnt - 1'b1;
                  end
               end
               S_DATA: begin
                  if (beat_cnt == BEAT_W'(BURST_LEN - 1)) begin
                     dqm_q    <= 1'b1;
                     wait_cnt <= WAIT_W'(RP_LEN - 1);
                     ofin     <= (RP_LEN == 1);
                     state    <= S_RP;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
               S_RP: begin
                  if (wait_cnt == '0) begin
                     state <= S_IDLE;
                  end else begin
                     wait_cnt <= wait_cnt - 1'b1;
                     ofin     <= (wait_cnt == WAIT_W'(1));
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

`ifdef SDRAM_BURST_READ_DQ_REG_EN
   logic [DATA_W-1:0]  dq_q;
   logic               dq_valid_q;
   logic [OBEAT_W-1:0] dq_beat_q;

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         dq_q       <= '0;
         dq_valid_q <= 1'b0;
         dq_beat_q  <= '0;
      end else begin
         dq_q       <= DRAM_DQ;
         dq_valid_q <= (state == S_DATA);
         dq_beat_q  <= beat_cnt[OBEAT_W-1:0];
      end
   end

   assign cap_valid = dq_valid_q;
   assign cap_data  = dq_q;
   assign cap_beat  = dq_beat_q;
`else
   assign cap_valid = (state == S_DATA);
   assign cap_data  = DRAM_DQ;
   assign cap_beat  = beat_cnt[OBEAT_W-1:0];
`endif

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         odata  <= '0;
         ovalid <= 1'b0;
         obeat  <= '0;
      end else begin
         ovalid <= cap_valid;
         if (cap_valid) begin
            odata <= cap_data;
            obeat <= cap_beat;
         end
      end
   end

   // Pins float whenever another engine owns the bus; the FSM keeps running regardless.
   assign DRAM_CLK   = ienb ? iclk     : 1'bz;
   assign DRAM_CKE   = ienb ? 1'b1     : 1'bz;
   assign DRAM_ADDR  = ienb ? addr_q   : {ROW_W{1'bz}};
   assign DRAM_BA    = ienb ? ba_q     : {BANK_W{1'bz}};
   assign DRAM_CS_N  = ienb ? cmd_q[3] : 1'bz;
   assign DRAM_RAS_N = ienb ? cmd_q[2] : 1'bz;
   assign DRAM_CAS_N = ienb ? cmd_q[1] : 1'bz;
   assign DRAM_WE_N  = ienb ? cmd_q[0] : 1'bz;
   assign DRAM_UDQM  = ienb ? dqm_q    : 1'bz;
   assign DRAM_LDQM  = ienb ? dqm_q    : 1'bz;

endmodule

// File: tb/tb_sdram_burst_read.sv
// Bench for sdram_burst_read: randomized requests against a cycle-schedule reference model,
// with a scoreboard queue of expected beats drained by a negedge monitor.
module tb_sdram_burst_read;
   localparam int ROW_W = 13, COL_W = 10, BANK_W = 2, DATA_W = 16;
   localparam int T_RCD = 2, CAS_LAT = 3, BURST_LEN = 4, T_RP = 2;
`ifdef SDRAM_BURST_READ_DQ_REG_EN
   localparam int DQ_REG = 1;
`else
   localparam int DQ_REG = 0;
`endif
   localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101;

   logic iclk = 1'b0;
   logic irst_n, ireq, ienb;
   logic [ROW_W-1:0]  irow;
   logic [COL_W-1:0]  icolumn;
   logic [BANK_W-1:0] ibank;
   logic [DATA_W-1:0] DRAM_DQ;
   wire obusy, ovalid, ofin;
   wire [DATA_W-1:0] odata;
   wire [1:0] obeat;
   wire DRAM_CLK, DRAM_CKE, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N, DRAM_UDQM, DRAM_LDQM;
   wire [ROW_W-1:0]  DRAM_ADDR;
   wire [BANK_W-1:0] DRAM_BA;

   sdram_burst_read dut (
      .iclk(iclk), .irst_n(irst_n), .ireq(ireq), .ienb(ienb),
      .irow(irow), .icolumn(icolumn), .ibank(ibank),
      .obusy(obusy), .odata(odata), .ovalid(ovalid), .obeat(obeat), .ofin(ofin),
      .DRAM_CLK(DRAM_CLK), .DRAM_CKE(DRAM_CKE), .DRAM_ADDR(DRAM_ADDR), .DRAM_BA(DRAM_BA),
      .DRAM_CS_N(DRAM_CS_N), .DRAM_RAS_N(DRAM_RAS_N), .DRAM_CAS_N(DRAM_CAS_N),
      .DRAM_WE_N(DRAM_WE_N), .DRAM_UDQM(DRAM_UDQM), .DRAM_LDQM(DRAM_LDQM), .DRAM_DQ(DRAM_DQ)
   );

   // clock / cycle index: cycle k runs from posedge k to posedge k+1
   always #5 iclk = ~iclk;
   int cyc = 0;
   always @(posedge iclk) cyc <= cyc + 1;

   // reference model state
   typedef struct {
      int                cyc;
      int                beat;
      logic [DATA_W-1:0] data;
      bit                chk_data;
   } beat_t;
   beat_t             exp_q[$];
   logic [18:0]       exp_cmd[int];
   logic [DATA_W-1:0] dq_sched[int];
   bit                fin_at[int];
   int  free_at = 0, busy_lo = -1, busy_hi = -2, dqm_lo = -1, dqm_hi = -2;
   bit  fixed_data = 0, mon_en = 0;
   int  checks = 0, passes = 0;

   function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) passes++;
      else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
   endfunction

   // An accepted request at cycle c0 fixes the whole future pin/data schedule.
   task automatic model_accept(input int c0, input logic [ROW_W-1:0] row,
                               input logic [COL_W-1:0] col, input logic [BANK_W-1:0] bank);
      int t_rd = c0 + 1 + T_RCD;
      int t_d0 = t_rd + CAS_LAT;
      int t_last = t_d0 + BURST_LEN - 1;
      int t_fin = t_last + T_RP + DQ_REG;
      logic [ROW_W-1:0]  ra = ROW_W'(col) + 13'h400;
      logic [DATA_W-1:0] d;
      exp_cmd[c0 + 1] = {ACT, row, bank};
      exp_cmd[t_rd]   = {RD, ra, bank};
      for (int n = 0; n < BURST_LEN; n++) begin
         d = fixed_data ? DATA_W'(16'hA0 + n) : DATA_W'($urandom);
         dq_sched[t_d0 + n] = d;
         exp_q.push_back('{t_d0 + n + 1 + DQ_REG, n, d, ienb});
      end
      fin_at[t_fin] = 1'b1;
      busy_lo = c0 + 1; busy_hi = t_fin;
      dqm_lo = t_rd; dqm_hi = t_last;
      free_at = t_fin + 1;
   endtask

   task automatic model_flush();
      exp_q.delete(); exp_cmd.delete(); dq_sched.delete(); fin_at.delete();
      busy_hi = -2; dqm_hi = -2;
   endtask

   // driver: present one cycle of request inputs, then feed DQ for the next cycle
   task automatic tick(input bit req, input logic [ROW_W-1:0] row,
                       input logic [COL_W-1:0] col, input logic [BANK_W-1:0] bank);
      ireq = req; irow = row; icolumn = col; ibank = bank;
      if (req && irst_n && cyc >= free_at) model_accept(cyc, row, col, bank);
      @(posedge iclk); #1;
      DRAM_DQ = dq_sched.exists(cyc) ? dq_sched[cyc] : DATA_W'($urandom);
   endtask

   task automatic tick_rand(input bit req);
      tick(req, ROW_W'($urandom), COL_W'($urandom), BANK_W'($urandom));
   endtask

   task automatic idle_until_free();
      for (int i = 0; i < 40 && cyc < free_at + 1; i++) tick_rand(1'b0);
   endtask

   // monitor / scoreboard
   always @(negedge iclk) begin
      if (irst_n && mon_en) begin
         chk("obusy", obusy, (cyc >= busy_lo && cyc <= busy_hi));
         chk("ofin", ofin, fin_at.exists(cyc));
         if (ienb) begin
            chk("cke", DRAM_CKE, 1'b1);
            if (exp_cmd.exists(cyc)) begin
               chk("cmd", {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N}, exp_cmd[cyc][18:15]);
               chk("addr", DRAM_ADDR, exp_cmd[cyc][14:2]);
               chk("ba", DRAM_BA, exp_cmd[cyc][1:0]);
            end else begin
               chk("cmd_nop", {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N}, NOP);
            end
            chk("dqm", {DRAM_UDQM, DRAM_LDQM}, (cyc >= dqm_lo && cyc <= dqm_hi) ? 2'b00 : 2'b11);
         end
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            $display("FAIL beat_missed cyc=%0d got=no_ovalid want=beat%0d_at_%0d", cyc, exp_q[0].beat, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
         if (ovalid) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
               chk("obeat", obeat, exp_q[0].beat);
               if (exp_q[0].chk_data) chk("odata", odata, exp_q[0].data);
               void'(exp_q.pop_front());
            end else begin
               checks++;
               $display("FAIL beat_extra cyc=%0d got=ovalid want=no_ovalid", cyc);
            end
         end
      end
   end

   int c0;
   initial begin
      irst_n = 1'b0; ireq = 1'b0; ienb = 1'b1; irow = '0; icolumn = '0; ibank = '0; DRAM_DQ = '0;
      repeat (2) @(posedge iclk);
      @(negedge iclk);
      chk("rst_cmd", {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N}, NOP);
      chk("rst_addr", DRAM_ADDR, 0);
      chk("rst_ba", DRAM_BA, 0);
      chk("rst_dqm", {DRAM_UDQM, DRAM_LDQM}, 2'b11);
      chk("rst_busy", obusy, 0);
      chk("rst_valid", ovalid, 0);
      chk("rst_fin", ofin, 0);
      chk("rst_beat", obeat, 0);
      chk("rst_data", odata, 0);
      @(posedge iclk); #1;
      irst_n = 1'b1; free_at = cyc; mon_en = 1'b1;
      tick_rand(1'b0);

      // single directed burst with known data words
      fixed_data = 1'b1;
      tick(1'b1, 13'h1ABC, 10'h004, 2'd2);
      fixed_data = 1'b0;
      idle_until_free();

      // back-to-back: ireq held high, pulses while busy are ignored
      repeat (30) tick_rand(1'b1);
      idle_until_free();

      // reset in the middle of a burst
      c0 = cyc;
      tick_rand(1'b1);
      while (cyc < c0 + 8) tick_rand($urandom_range(0, 1) == 1);
      irst_n = 1'b0;
      #1;
      chk("mid_rst_cmd", {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N}, NOP);
      chk("mid_rst_valid", ovalid, 0);
      chk("mid_rst_busy", obusy, 0);
      chk("mid_rst_dqm", {DRAM_UDQM, DRAM_LDQM}, 2'b11);
      chk("mid_rst_fin", ofin, 0);
      model_flush();
      tick_rand(1'b1);
      tick_rand(1'b1);
      irst_n = 1'b1; free_at = cyc;
      tick_rand(1'b1);
      idle_until_free();

      // bus not owned for a whole burst: FSM timing must be unchanged
      ienb = 1'b0;
      tick_rand(1'b1);
      idle_until_free();
      ienb = 1'b1;
      tick_rand(1'b0);

      // randomized traffic
      repeat (400) tick_rand($urandom_range(0, 2) == 0);
      ireq = 1'b0;
      idle_until_free();
      repeat (5) tick_rand(1'b0);
      chk("beats_left", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
